// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through write-allocate data cache controller
// Optional CACHE_CTRL_STATS_EN adds hit_count/access_count outputs.
module cache_ctrl #(
    parameter int INDEX_BITS  = 10,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [14:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        memRead,
    output logic        memWrite,
    output logic [14:0] address,
    output logic [31:0] writeData0,
    output logic [31:0] writeData1,
    output logic [31:0] writeData2,
    output logic [31:0] writeData3,
    input  logic [31:0] Data0,
    input  logic [31:0] Data1,
    input  logic [31:0] Data2,
    input  logic [31:0] Data3
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] access_count
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 13 - INDEX_BITS;
    localparam int CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [127:0]          data_mem [LINES];
    logic [LINES-1:0]      valid_q, valid_d;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [127:0]          wbuf_q, wbuf_d;
    logic [127:0]          wd_q, wd_d;
    logic [14:0]           addr_q, addr_d;

    logic [TAG_BITS-1:0]   tag_w;
    logic [INDEX_BITS-1:0] idx_w;
    logic [1:0]            off_w;
    logic [14:0]           blk_addr;
    logic [127:0]          line_rd;
    logic [127:0]          fetched;
    logic [127:0]          line_wdata;
    logic [127:0]          wd_out;
    logic                  line_we;
    logic                  hit;
    logic                  fetch_last;

    assign tag_w      = cpu_addr[14:2+INDEX_BITS];
    assign idx_w      = cpu_addr[INDEX_BITS+1:2];
    assign off_w      = cpu_addr[1:0];
    assign blk_addr   = {cpu_addr[14:2], 2'b00};
    assign line_rd    = data_mem[idx_w];
    assign fetched    = {Data3, Data2, Data1, Data0};
    assign hit        = valid_q[idx_w] && (tag_mem[idx_w] == tag_w);
    assign fetch_last = (cnt_q == CW'(MEM_LATENCY - 1));

    assign writeData0 = wd_out[31:0];
    assign writeData1 = wd_out[63:32];
    assign writeData2 = wd_out[95:64];
    assign writeData3 = wd_out[127:96];

    function automatic logic [127:0] merge_word(input logic [127:0] line,
                                                input logic [1:0]   off,
                                                input logic [31:0]  w);
        logic [127:0] r;
        r = line;
        r[{off, 5'b0} +: 32] = w;
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wbuf_d     = wbuf_q;
        wd_d       = wd_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        line_we    = 1'b0;
        line_wdata = wbuf_q;
        cpu_ready  = 1'b0;
        cpu_rdata  = 32'd0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        address    = addr_q;
        wd_out     = wd_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_rd) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = line_rd[{off_w, 5'b0} +: 32];
                    end else begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end
                end else if (cpu_wr) begin
                    if (hit) begin
                        wbuf_d  = merge_word(line_rd, off_w, cpu_wdata);
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end
                end
            end
            S_FETCH: begin
                memRead = 1'b1;
                address = blk_addr;
                addr_d  = blk_addr;
                if (fetch_last) begin
                    line_we        = 1'b1;
                    line_wdata     = fetched;
                    valid_d[idx_w] = 1'b1;
                    cnt_d          = '0;
                    if (cpu_wr) begin
                        // store miss: allocate, then push the merged line through WRITE
                        wbuf_d  = merge_word(fetched, off_w, cpu_wdata);
                        state_d = S_WRITE;
                    end else begin
                        cpu_ready = 1'b1;
                        cpu_rdata = fetched[{off_w, 5'b0} +: 32];
                        state_d   = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WRITE: begin
                memWrite   = 1'b1;
                address    = blk_addr;
                addr_d     = blk_addr;
                wd_out     = wbuf_q;
                wd_d       = wbuf_q;
                line_we    = 1'b1;
                line_wdata = wbuf_q;
                cpu_ready  = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wbuf_q  <= '0;
            wd_q    <= '0;
            addr_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wbuf_q  <= wbuf_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    // Line payload needs no reset: validity alone gates its use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[idx_w] <= line_wdata;
            tag_mem[idx_w]  <= tag_w;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_q, hit_d, acc_q, acc_d;

    always_comb begin
        hit_d = hit_q;
        acc_d = acc_q;
        if (state_q == S_IDLE && hit && (cpu_rd || cpu_wr))
            hit_d = hit_q + 32'd1;
        if (cpu_ready)
            acc_d = acc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q <= '0;
            acc_q <= '0;
        end else begin
            hit_q <= hit_d;
            acc_q <= acc_d;
        end
    end

    assign hit_count    = hit_q;
    assign access_count = acc_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed plus randomized check of cache_ctrl against a word-level memory model
// Optional CACHE_CTRL_STATS_EN also checks hit_count/access_count.
module tb_cache_ctrl;

    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, memRead, memWrite;
    logic [14:0] address;
    logic [31:0] writeData0, writeData1, writeData2, writeData3;
    logic [31:0] Data0, Data1, Data2, Data3;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_count, access_count;
`endif

    logic [31:0] sim_mem [32768];
    logic [31:0] ref_mem [32768];
    bit          mvalid  [1024];
    logic [2:0]  mtag    [1024];

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_hit = 0;
    int          exp_acc = 0;
    int          last_lat;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    assign Data0 = sim_mem[{address[14:2], 2'd0}];
    assign Data1 = sim_mem[{address[14:2], 2'd1}];
    assign Data2 = sim_mem[{address[14:2], 2'd2}];
    assign Data3 = sim_mem[{address[14:2], 2'd3}];

    cache_ctrl #(.INDEX_BITS(10), .MEM_LATENCY(ML)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .memRead(memRead), .memWrite(memWrite), .address(address),
        .writeData0(writeData0), .writeData1(writeData1),
        .writeData2(writeData2), .writeData3(writeData3),
        .Data0(Data0), .Data1(Data1), .Data2(Data2), .Data3(Data3)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_count(hit_count), .access_count(access_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // One CPU request; expectations come from the word-level memory and the valid/tag model.
    task automatic do_req(input bit is_wr, input logic [14:0] a, input logic [31:0] wd);
        logic [9:0]   idx;
        logic [14:0]  blk;
        logic [14:0]  wa;
        logic [127:0] wblk;
        bit           h, done, bad_addr;
        int           cycles, nrd, nwr, exp_lat;
        idx      = a[11:2];
        blk      = {a[14:2], 2'b00};
        h        = mvalid[idx] && (mtag[idx] == a[14:12]);
        exp_lat  = is_wr ? (h ? 2 : ML + 2) : (h ? 1 : ML + 1);
        cpu_rd   = !is_wr;
        cpu_wr   = is_wr;
        cpu_addr = a;
        cpu_wdata = wd;
        cycles = 0; nrd = 0; nwr = 0; done = 0; bad_addr = 0;
        wa = '0; wblk = '0; last_rdata = '0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (memRead) begin
                nrd++;
                if (address !== blk) bad_addr = 1;
            end
            if (memWrite) begin
                nwr++;
                wa   = address;
                wblk = {writeData3, writeData2, writeData1, writeData0};
                sim_mem[{address[14:2], 2'd0}] = writeData0;
                sim_mem[{address[14:2], 2'd1}] = writeData1;
                sim_mem[{address[14:2], 2'd2}] = writeData2;
                sim_mem[{address[14:2], 2'd3}] = writeData3;
            end
            if (cpu_ready) begin
                done = 1;
                last_rdata = cpu_rdata;
            end
        end
        last_lat = cycles;
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        check("req_done", 32'(done), 32'd1);
        check("latency", 32'(cycles), 32'(exp_lat));
        check("memread_cycles", 32'(nrd), h ? 32'd0 : 32'(ML));
        check("fetch_address", 32'(bad_addr), 32'd0);
        check("memwrite_pulses", 32'(nwr), is_wr ? 32'd1 : 32'd0);
        if (is_wr) begin
            ref_mem[a] = wd;
            check("write_address", 32'(wa), 32'(blk));
            for (int i = 0; i < 4; i++)
                check("write_word", wblk[i*32 +: 32], ref_mem[blk + 15'(i)]);
        end else begin
            check("load_data", last_rdata, ref_mem[a]);
        end
        mvalid[idx] = 1'b1;
        mtag[idx]   = a[14:12];
        exp_acc++;
        if (h) exp_hit++;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [14:0] ra;
        for (int i = 0; i < 32768; i++) begin
            v = $urandom;
            sim_mem[i] = v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < 4; i++) begin
            sim_mem[15'h0404 + i] = 32'h11 * (i + 1);
            ref_mem[15'h0404 + i] = 32'h11 * (i + 1);
            sim_mem[15'h1008 + i] = 32'hA + i;
            ref_mem[15'h1008 + i] = 32'hA + i;
        end
        for (int i = 0; i < 1024; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end

        rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_memread", 32'(memRead), 32'd0);
        check("rst_memwrite", 32'(memWrite), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_wd0", writeData0, 32'd0);
        check("rst_wd3", writeData3, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        do_req(0, 15'h0404, 32'd0);
        check("tp_miss_data", last_rdata, 32'h11);
        check("tp_miss_lat", 32'(last_lat), 32'(ML + 1));
        do_req(0, 15'h0406, 32'd0);
        check("tp_hit_data", last_rdata, 32'h33);
        check("tp_hit_lat", 32'(last_lat), 32'd1);
        do_req(1, 15'h0405, 32'hDEADBEEF);
        check("tp_wr_mem1", sim_mem[15'h0405], 32'hDEADBEEF);
        check("tp_wr_mem2", sim_mem[15'h0406], 32'h33);
        do_req(0, 15'h0405, 32'd0);
        check("tp_rd_after_wr", last_rdata, 32'hDEADBEEF);
        do_req(1, 15'h1008, 32'h5);
        check("tp_wmiss_lat", 32'(last_lat), 32'(ML + 2));
        check("tp_wmiss_mem0", sim_mem[15'h1008], 32'h5);
        check("tp_wmiss_mem1", sim_mem[15'h1009], 32'hB);
        do_req(0, 15'h0010, 32'd0);
        do_req(0, 15'h1010, 32'd0);
        check("tp_conflict_lat", 32'(last_lat), 32'(ML + 1));
        do_req(0, 15'h0010, 32'd0);
        check("tp_reload_lat", 32'(last_lat), 32'(ML + 1));

        // reset during the second fetch cycle of a load miss
        cpu_rd = 1'b1; cpu_addr = 15'h2020;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_memread", 32'(memRead), 32'd0);
        check("midrst_ready", 32'(cpu_ready), 32'd0);
        check("midrst_address", 32'(address), 32'd0);
        cpu_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_memwrite", 32'(memWrite), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
        exp_hit = 0;
        exp_acc = 0;
        do_req(0, 15'h2020, 32'd0);
        check("postrst_miss_lat", 32'(last_lat), 32'(ML + 1));

        for (int n = 0; n < 200; n++) begin
            ra = {3'($urandom_range(0, 7)), 7'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_req($urandom_range(0, 2) == 0, ra, $urandom);
        end

`ifdef CACHE_CTRL_STATS_EN
        check("stat_hit", hit_count, 32'(exp_hit));
        check("stat_access", access_count, 32'(exp_acc));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
